// File: rtl/mq_byte_out.sv
// MQ coder byte-output stage: pending-byte carry absorption, FIFO output, byte pointer, flush (MQ_OUT_EOC_EN adds FF D9 terminator).
// Latency: push to out_byte in 1 cycle; backpressure: in_ready drops when FIFO full or flushing, no path from out_ready.
module mq_byte_out #(
  parameter int DEPTH = 8,
  parameter int BP_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  input  logic            carry_in,
  output logic            in_ready,
  input  logic            flush,
  output logic [7:0]      out_byte,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BP_W-1:0] bp,
  output logic            carry_err,
  output logic            flush_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FL_PEND = 3'd1,
`ifdef MQ_OUT_EOC_EN
    MARK0   = 3'd2,
    MARK1   = 3'd3,
`endif
    DONE    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [7:0]       pend, pend_inc, push_dat, fsm_dat;
  logic             pend_v;
  logic             accept, carry_only, pop, space, push, fsm_push;

  always_comb begin
    in_ready   = rst & (state == IDLE) & (count < FULL);
    accept     = byte_valid & in_ready;
    carry_only = carry_in & ~byte_valid & (state == IDLE);
    pop        = out_valid & out_ready;
    // FSM pushes may use the slot freed by a same-cycle pop
    space      = (count != FULL) | pop;
    pend_inc   = (carry_in && pend != 8'hFF) ? pend + 8'd1 : pend;
    rd_nxt     = rd_ptr + PTR_W'(1);
  end

  always_comb begin
    state_nxt  = state;
    fsm_push   = 1'b0;
    fsm_dat    = pend;
    flush_done = 1'b0;
    case (state)
      IDLE: if (flush) state_nxt = FL_PEND;
      FL_PEND: begin
        if (!pend_v || space) begin
          fsm_push = pend_v;
`ifdef MQ_OUT_EOC_EN
          state_nxt = MARK0;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef MQ_OUT_EOC_EN
      MARK0: begin
        fsm_dat = 8'hFF;
        if (space) begin
          fsm_push  = 1'b1;
          state_nxt = MARK1;
        end
      end
      MARK1: begin
        fsm_dat = 8'hD9;
        if (space) begin
          fsm_push  = 1'b1;
          state_nxt = DONE;
        end
      end
`endif
      DONE: begin
        if (count == '0) begin
          flush_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push      = (accept & pend_v) | fsm_push;
    push_dat  = fsm_push ? fsm_dat : pend_inc;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pend      <= '0;
      pend_v    <= 1'b0;
      carry_err <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      bp        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pend   <= byte_in;
        pend_v <= 1'b1;
        if (carry_in && (!pend_v || pend == 8'hFF)) carry_err <= 1'b1;
      end else if (carry_only) begin
        if (pend_v && pend != 8'hFF) pend <= pend + 8'd1;
        else                         carry_err <= 1'b1;
      end
      if (flush_done) pend_v <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        bp     <= bp + BP_W'(1);
      end
      if (pop) rd_ptr <= rd_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      // out_byte is a registered copy of the entry at the read pointer
      if (pop) begin
        if (count >= CNT_W'(2)) out_byte <= mem[rd_nxt];
        else if (push)          out_byte <= push_dat;
      end else if (count == '0 && push) begin
        out_byte <= push_dat;
      end
    end
  end

endmodule

// File: tb/tb_mq_byte_out.sv
// Randomised scoreboard bench for mq_byte_out (DEPTH=8, BP_W=4 so bp wraps quickly).
module tb_mq_byte_out;
  localparam int DEPTH = 8;
  localparam int BP_W  = 4;
  localparam int BP_M  = 1 << BP_W;
`ifdef MQ_OUT_EOC_EN
  localparam bit EOC = 1'b1;
`else
  localparam bit EOC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      byte_in = '0;
  logic            byte_valid = 1'b0, carry_in = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic            in_ready, out_valid, carry_err, flush_done;
  logic [7:0]      out_byte;
  logic [BP_W-1:0] bp;

  always #5 clk = ~clk;

  mq_byte_out #(.DEPTH(DEPTH), .BP_W(BP_W)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .carry_in(carry_in), .in_ready(in_ready), .flush(flush),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .bp(bp), .carry_err(carry_err), .flush_done(flush_done)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  // reference model: committed-byte stream, pending byte, FIFO occupancy
  logic [7:0] m_pend;
  bit         m_pv, m_idle, m_err, fd_obs;
  int         m_cnt, m_bp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_byte: unexpected byte 0x%0h, nothing expected at %0t", out_byte, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_byte", out_byte, mon_e);
      end
    end
  end

  task automatic commit(input logic [7:0] v);
    exp_q.push_back(v);
    m_bp = (m_bp + 1) % BP_M;
  endtask

  task automatic cycle(input bit bv, input logic [7:0] b, input bit cin, input bit ordy, input bit fl);
    bit acc, pop;
    logic [7:0] v;
    byte_valid = bv; byte_in = b; carry_in = cin; out_ready = ordy; flush = fl;
    @(negedge clk);
    fd_obs = flush_done;
    chk("carry_err", carry_err, m_err);
    if (m_idle) begin
      chk("in_ready", in_ready, m_cnt < DEPTH);
      chk("out_valid", out_valid, m_cnt > 0);
      chk("bp", bp, m_bp);
      chk("flush_done_idle", flush_done, 0);
    end else begin
      chk("in_ready_flushing", in_ready, 0);
    end
    @(posedge clk);
    if (m_idle) begin
      acc = bv && (m_cnt < DEPTH);
      pop = (m_cnt > 0) && ordy;
      if (acc) begin
        if (m_pv) begin
          v = m_pend;
          if (cin) begin
            if (m_pend == 8'hFF) m_err = 1'b1;
            else                 v = m_pend + 8'd1;
          end
          commit(v);
          m_cnt++;
        end else if (cin) begin
          m_err = 1'b1;
        end
        m_pend = b;
        m_pv   = 1'b1;
      end else if (cin && !bv) begin
        if (m_pv && m_pend != 8'hFF) m_pend = m_pend + 8'd1;
        else                         m_err = 1'b1;
      end
      if (pop) m_cnt--;
      if (fl) begin
        m_idle = 1'b0;
        if (m_pv) commit(m_pend);
        if (EOC) begin
          commit(8'hFF);
          commit(8'hD9);
        end
        m_pv = 1'b0;
      end
    end else if (fd_obs) begin
      m_idle = 1'b1;
      m_cnt  = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; byte_valid = 1'b0; carry_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_bp", bp, 0);
    chk("rst_carry_err", carry_err, 0);
    chk("rst_flush_done", flush_done, 0);
    exp_q.delete();
    m_pend = '0; m_pv = 1'b0; m_idle = 1'b1; m_err = 1'b0; m_cnt = 0; m_bp = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && m_cnt > 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_flush(input bit chk_lat, input int lat_exp);
    int pulses, lat;
    bit r;
    pulses = 0;
    lat    = -1;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 200 && !m_idle; k++) begin
      r = chk_lat ? 1'b1 : ($urandom_range(0, 2) != 0);
      cycle(1'b0, 8'h00, 1'b0, r, 1'b0);
      if (fd_obs) begin
        pulses++;
        lat = k;
      end
    end
    if (!m_idle) begin
      m_idle = 1'b1;
      m_cnt  = 0;
    end
    chk("flush_done_pulses", pulses, 1);
    if (chk_lat) chk("flush_latency", lat, lat_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    bit acc;
    do_reset();

    // basic stream: last byte stays pending
    cycle(1'b1, 8'h12, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h34, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h56, 1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("bp_after_three", bp, 2);

    // carry onto pending byte, then illegal carry onto 0xFF
    cycle(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("carry_err_legal", carry_err, 0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    drain();
    chk("carry_err_ff", carry_err, 1);

    // byte pointer wrap: 18 accepts = 17 commits
    do_reset();
    for (int k = 0; k < 18; k++) cycle(1'b1, 8'(k), 1'b0, 1'b1, 1'b0);
    drain();
    chk("bp_wrap", bp, 1);

    // backpressure: one pending plus DEPTH in FIFO, then drain in order
    do_reset();
    i = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      acc = m_cnt < DEPTH;
      cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
      if (acc) i++;
    end
    chk("accepts_when_full", i, DEPTH + 1);
    chk("in_ready_full", in_ready, 0);
    for (int c = 0; c < 4 * DEPTH; c++) begin
      acc = m_cnt < DEPTH;
      cycle(i < DEPTH + 2, 8'h40 + 8'(i), 1'b0, 1'b1, 1'b0);
      if (acc && i < DEPTH + 2) i++;
    end
    chk("backpressure_queue_empty", exp_q.size(), 0);

    // flush with pending 0xA5 from an empty FIFO
    cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    drain();
    do_flush(1'b1, EOC ? 5 : 3);
    cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("flush_queue_empty", exp_q.size(), 0);

    // random traffic with occasional flushes
    for (int c = 0; c < 600; c++) begin
      if (c % 97 == 96) do_flush(1'b0, 0);
      else cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, 1'b0);
    end
    drain();

    // reset in the middle of a flush
    do_reset();
    cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    drain();
    chk("bp_after_abort", bp, 1);

    drain();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mq_byte_out.md
# mq_byte_out

Parametrised byte-output stage of the MQ arithmetic coder, sitting between the coder core and the downstream codestream packer. Holds the most recent coded byte as a pending byte so a late carry can still increment it, then releases committed bytes into an output FIFO. The FIFO is drained over a valid/ready handshake. Also maintains the byte pointer (count of committed bytes), detects illegal carries, and runs a flush sequence at end of codeblock.

## Interface
- `DEPTH`, 8: output FIFO depth in bytes; power of two, 2..256.
- `BP_W`, 16: byte-pointer width; wraps modulo 2^BP_W.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset; all state cleared while low.
- `byte_in` input 8: coded byte from core.
- `byte_valid` input 1: `byte_in` offered this cycle.
- `carry_in` input 1: add 1 to the pending byte. Applies in the same cycle as `byte_valid`, or alone.
- `in_ready` output 1: core may present a byte.
- `flush` input 1: start end-of-codeblock flush; single-cycle pulse, sampled only in IDLE.
- `out_byte` output 8: FIFO head.
- `out_valid` output 1: `out_byte` valid.
- `out_ready` input 1: downstream accepts `out_byte`.
- `bp` output BP_W: number of bytes committed to the FIFO since reset.
- `carry_err` output 1: sticky; a carry hit a pending 0xFF or an empty pending slot.
- `flush_done` output 1: one-cycle pulse when flush is complete.

## Operation
- State: `pend` (8b), `pend_v`, FIFO (`DEPTH` x 8, registered head), `count` (0..DEPTH).
- Accept condition is `byte_valid & in_ready`, where `in_ready = (state==IDLE) & (count < DEPTH)`.
- Accept with `pend_v=0`:
  - `pend` takes `byte_in`; `pend_v` is set.
  - If `carry_in=1` in the same cycle, the carry is dropped and `carry_err` is set.
- Accept with `pend_v=1`:
  - `pend + carry_in` (8-bit, no wrap allowed) is pushed to the FIFO.
  - `pend` takes `byte_in`; `bp` increments by 1.
- `carry_in` without accept: `pend` increments in place if `pend_v=1`; otherwise `carry_err` is set.
- Carry onto `pend==0xFF`: `pend` is left unchanged and `carry_err` is set. The coder's bit-stuffing guarantees this never happens legally.
- `byte_valid` while `in_ready=0`: ignored. The core must hold the byte and carry until accepted.
- FSM states and transitions:
  - IDLE to FL_PEND on `flush`.
  - FL_PEND pushes `pend` if `pend_v`, then goes to MARK0 (with `MQ_OUT_EOC_EN`) or DONE. It waits while the FIFO is full.
  - MARK0 pushes 0xFF, then goes to MARK1. MARK1 pushes 0xD9, then goes to DONE. Each waits while the FIFO is full.
  - DONE waits for `count==0`, then pulses `flush_done` and returns to IDLE with `pend_v=0`.
- Every FIFO push increments `bp`, including the marker bytes.
- FIFO behaviour:
  - A pop occurs on `out_valid & out_ready`.
  - Simultaneous push and pop at full is allowed for FSM pushes. The input path still sees `in_ready=0` when `count==DEPTH`.
  - Pointers wrap modulo DEPTH.
- `flush` outside IDLE is ignored.

## Timing
- Reset values:
  - `out_valid=0`, `in_ready=0` while `rst` is low, 1 after release.
  - `out_byte=0x00`, `bp=0`, `carry_err=0`, `flush_done=0`.
  - FSM in IDLE, `pend_v=0`.
- Push-to-output latency is one cycle: a byte pushed at edge N is on `out_byte` with `out_valid` after edge N.
- `bp` updates on the same edge as the push.
- `in_ready` is combinational from registered state only, with no path from `out_ready`.
- Flush latency with an empty FIFO and a ready sink:
  - Without the macro, `flush_done` pulses 3 cycles after `flush`.
  - With the macro, it pulses 5 cycles after `flush`.
- Asserting `rst` low mid-operation discards pending and FIFO contents immediately. The FSM aborts.

## Configuration
- `MQ_OUT_EOC_EN` defined: flush appends the two-byte terminator 0xFF, 0xD9 after the pending byte, and `bp` counts both bytes.
- `MQ_OUT_EOC_EN` undefined: MARK0 and MARK1 are not built; FL_PEND goes directly to DONE.

## Test plan
- Reset, then bytes 0x12, 0x34, 0x56 with `out_ready=1`: out 0x12, 0x34. 0x56 stays pending; `bp=2`.
- Pending 0x7E, then `carry_in` alone, then byte 0x00: out 0x7F, `carry_err=0`. A `carry_in` with `pend=0xFF` sets `carry_err`, and 0xFF is emitted unchanged.
- `out_ready=0` with DEPTH+2 bytes offered:
  - After DEPTH+1 accepts (one pending, DEPTH in the FIFO), `in_ready=0`.
  - Raise `out_ready`: bytes drain in order with no loss or duplication.
- `bp` preloaded near wrap (BP_W=4, 17 commits): `bp` reads 1.
- Flush with pending 0xA5:
  - With macro: stream ends A5 FF D9 and `flush_done` pulses once.
  - Without macro: stream ends A5.
  - In both cases `pend_v=0` afterwards.
- `rst` low during MARK0: outputs return to reset values. After release, a new byte is accepted normally.
